// File: rtl/pattern_sel_pkg.sv
// Shared types and helpers for the test-pattern selector.
package pattern_sel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } sel_st_t;

    localparam int DEF_NPAT = 8;

    // dir = 1 steps forward, dir = 0 steps back; both wrap within 0..npat-1.
    function automatic int wrap_step(input int idx, input logic dir, input int npat);
        if (dir) begin
            return (idx == npat - 1) ? 0 : idx + 1;
        end
        return (idx == 0) ? npat - 1 : idx - 1;
    endfunction

endpackage

// File: rtl/pattern_sel_ctrl_frame_counter.sv
// Frame-pulse counter: done fires on the tick that reaches LIMIT, then restarts from zero.
module frame_counter #(
    parameter int LIMIT = 2,
    parameter int W     = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic done
);

    logic [W-1:0] count;

    assign done = tick && !clear && (count == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_sel_ctrl.sv
// Press-driven test-pattern index, applied only on frame boundaries with a post-apply holdoff.
// Optional idle auto-advance is enabled by defining PATTERN_SEL_AUTO_CYCLE_EN.
//
// state | meaning
// IDLE  | target equals applied pattern, nothing to do
// PEND  | target differs, apply on next frame_start_i
// HOLD  | just applied, waiting HOLD_FRAMES frames before another apply
module pattern_sel_ctrl
    import pattern_sel_pkg::*;
#(
    parameter int  NPAT        = DEF_NPAT,
    parameter int  RST_PAT     = 0,
    parameter int  HOLD_FRAMES = 2,
    parameter int  AUTO_FRAMES = 120,
    localparam int PW          = (NPAT <= 2) ? 1 : $clog2(NPAT)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          next_i,
    input  logic          prev_i,
    input  logic          frame_start_i,
    output logic [PW-1:0] pattern_o,
    output logic          pending_o,
    output logic          changed_o
);

    if (NPAT < 2 || NPAT > 256) begin : g_bad_npat
        $error("NPAT out of range 2..256");
    end
    if (RST_PAT < 0 || RST_PAT >= NPAT) begin : g_bad_rst_pat
        $error("RST_PAT must be below NPAT");
    end
    if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255) begin : g_bad_hold
        $error("HOLD_FRAMES out of range 1..255");
    end
    if (AUTO_FRAMES < 1 || AUTO_FRAMES > 65535) begin : g_bad_auto
        $error("AUTO_FRAMES out of range 1..65535");
    end

    sel_st_t       state;
    logic [PW-1:0] target;
    logic [PW-1:0] target_next;
    logic [PW-1:0] pattern_next;
    logic          apply;
    logic          hold_done;

    frame_counter #(.LIMIT(HOLD_FRAMES), .W(16)) u_hold_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (state != HOLD),
        .tick  (frame_start_i),
        .done  (hold_done)
    );

`ifdef PATTERN_SEL_AUTO_CYCLE_EN
    logic auto_done;

    frame_counter #(.LIMIT(AUTO_FRAMES), .W(16)) u_auto_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear ((state != IDLE) || next_i || prev_i),
        .tick  (frame_start_i),
        .done  (auto_done)
    );
`endif

    // The apply uses target as registered before this cycle, so a coincident press rolls into the next apply.
    always_comb begin
        target_next = target;
        if (next_i && !prev_i) begin
            target_next = PW'(wrap_step(int'(target), 1'b1, NPAT));
        end else if (prev_i && !next_i) begin
            target_next = PW'(wrap_step(int'(target), 1'b0, NPAT));
        end
`ifdef PATTERN_SEL_AUTO_CYCLE_EN
        else if (auto_done) begin
            target_next = PW'(wrap_step(int'(target), 1'b1, NPAT));
        end
`endif
        apply        = (state == PEND) && frame_start_i;
        pattern_next = apply ? target : pattern_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            target    <= PW'(RST_PAT);
            pattern_o <= PW'(RST_PAT);
            pending_o <= 1'b0;
            changed_o <= 1'b0;
        end else begin
            target    <= target_next;
            pattern_o <= pattern_next;
            pending_o <= (target_next != pattern_next);
            changed_o <= apply;
            case (state)
                IDLE: begin
                    if (target_next != pattern_o) begin
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (frame_start_i) begin
                        state <= HOLD;
                    end else if (target_next == pattern_o) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        state <= (target_next != pattern_o) ? PEND : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_sel_ctrl.sv
// Self-checking bench for pattern_sel_ctrl: frame-level reference model plus directed literal checks.
module tb_pattern_sel_ctrl;

    localparam int NPAT  = 8;
    localparam int RSTP  = 0;
    localparam int HOLDF = 2;
    localparam int AUTOF = 120;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       next_i = 1'b0;
    logic       prev_i = 1'b0;
    logic       frame_start_i = 1'b0;
    logic [2:0] pattern_o;
    logic       pending_o;
    logic       changed_o;

    int tests = 0;
    int fails = 0;
    int changed_cnt = 0;

    pattern_sel_ctrl #(
        .NPAT(NPAT), .RST_PAT(RSTP), .HOLD_FRAMES(HOLDF), .AUTO_FRAMES(AUTOF)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .next_i        (next_i),
        .prev_i        (prev_i),
        .frame_start_i (frame_start_i),
        .pattern_o     (pattern_o),
        .pending_o     (pending_o),
        .changed_o     (changed_o)
    );

    always #5 clk = ~clk;

    // Reference model: an apply happens on any frame with no holdoff left and a target that differs.
    int m_tgt, m_pat, m_hold, m_idle, m_d;
    bit m_chg, m_pend, m_valid, m_apply, m_is_idle;

    always @(posedge clk) begin
        if (rst_i) begin
            m_tgt = RSTP; m_pat = RSTP; m_hold = 0; m_idle = 0;
            m_chg = 0; m_pend = 0; m_valid = 1;
        end else begin
            m_apply   = frame_start_i && (m_hold == 0) && (m_tgt != m_pat);
            m_is_idle = (m_hold == 0) && (m_tgt == m_pat);
            m_d = (next_i && !prev_i) ? 1 : ((prev_i && !next_i) ? -1 : 0);
`ifdef PATTERN_SEL_AUTO_CYCLE_EN
            if (!m_is_idle || next_i || prev_i) begin
                m_idle = 0;
            end else if (frame_start_i) begin
                m_idle = m_idle + 1;
                if (m_idle == AUTOF) begin
                    m_d = 1;
                    m_idle = 0;
                end
            end
`endif
            if (frame_start_i && m_hold > 0) m_hold = m_hold - 1;
            if (m_apply) begin
                m_pat  = m_tgt;
                m_hold = HOLDF;
            end
            m_tgt  = (m_tgt + m_d + NPAT) % NPAT;
            m_chg  = m_apply;
            m_pend = (m_tgt != m_pat);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests = tests + 1;
            if (int'(pattern_o) != m_pat || pending_o != m_pend || changed_o != m_chg) begin
                fails = fails + 1;
                $display("FAIL cycle_model t=%0t: got pat=%0d pend=%0b chg=%0b, want pat=%0d pend=%0b chg=%0b",
                         $time, pattern_o, pending_o, changed_o, m_pat, m_pend, m_chg);
            end
            if (changed_o) changed_cnt = changed_cnt + 1;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        tests = tests + 1;
        if (got != want) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic tick(input logic nx, input logic pv, input logic fs);
        next_i = nx; prev_i = pv; frame_start_i = fs;
        @(posedge clk);
        #1;
        next_i = 1'b0; prev_i = 1'b0; frame_start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic frame();
        tick(1'b0, 1'b0, 1'b1);
        idle(3);
    endtask

    int c0;

    initial begin
        // Reset, then three frames with no presses
        idle(3);
        rst_i = 1'b0;
        frame(); frame(); frame();
        chk("rst_pattern", int'(pattern_o), 0);
        chk("rst_pending", int'(pending_o), 0);
        chk("rst_no_changed", changed_cnt, 0);
        chk("rst_model_pat", m_pat, 0);

        // Single next press, apply on a later frame with one clock latency
        idle(6);
        tick(1'b1, 1'b0, 1'b0);
        chk("next_pending_now", int'(pending_o), 1);
        chk("next_not_applied", int'(pattern_o), 0);
        idle(38);
        chk("pend_before_frame", int'(pattern_o), 0);
        tick(1'b0, 1'b0, 1'b1);
        chk("apply_pattern", int'(pattern_o), 1);
        chk("apply_changed", int'(changed_o), 1);
        chk("apply_model_pat", m_pat, 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("changed_one_cycle", int'(changed_o), 0);
        idle(2);
        frame(); frame();

        // Wrap in both directions
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        frame();
        chk("wrap_prev_to_7", int'(pattern_o), 7);
        frame(); frame();
        tick(1'b1, 1'b0, 1'b0);
        frame();
        chk("wrap_next_to_0", int'(pattern_o), 0);
        chk("wrap_model_0", m_pat, 0);
        frame(); frame();
        tick(1'b0, 1'b1, 1'b0);
        frame();
        chk("wrap_prev_0_to_7", int'(pattern_o), 7);
        frame(); frame();

        // Holdoff: press right after an apply lands on the third following frame
        tick(1'b1, 1'b0, 1'b0);
        frame();
        chk("hold_apply_F", int'(pattern_o), 0);
        tick(1'b1, 1'b0, 1'b0);
        frame();
        chk("hold_F1_blocked", int'(pattern_o), 0);
        frame();
        chk("hold_F2_blocked", int'(pattern_o), 0);
        chk("hold_F2_pending", int'(pending_o), 1);
        frame();
        chk("hold_F3_applied", int'(pattern_o), 1);
        frame(); frame();

        // Simultaneous presses cancel; next then prev returns to idle without an apply
        c0 = changed_cnt;
        tick(1'b1, 1'b1, 1'b0);
        chk("both_pending", int'(pending_o), 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("np_pending_hi", int'(pending_o), 1);
        tick(1'b0, 1'b1, 1'b0);
        chk("np_pending_lo", int'(pending_o), 0);
        frame(); frame();
        chk("np_pattern", int'(pattern_o), 1);
        chk("np_no_changed", changed_cnt - c0, 0);

        // Several presses inside one frame apply as a single step
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        frame();
        chk("acc_to_6", int'(pattern_o), 6);
        frame(); frame();
        c0 = changed_cnt;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        frame();
        chk("acc_6_plus3_to_1", int'(pattern_o), 1);
        chk("acc_single_step", changed_cnt - c0, 1);
        frame(); frame();

        // Press coinciding with the applying frame is deferred
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("coinc_applied", int'(pattern_o), 2);
        chk("coinc_pending", int'(pending_o), 1);
        idle(3);
        frame(); frame();
        chk("coinc_still_2", int'(pattern_o), 2);
        frame();
        chk("coinc_then_3", int'(pattern_o), 3);
        frame(); frame();

        // Reset mid-holdoff drops the queued request
        tick(1'b1, 1'b0, 1'b0);
        frame();
        chk("pre_rst_apply", int'(pattern_o), 4);
        tick(1'b1, 1'b0, 1'b0);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        chk("mid_rst_pattern", int'(pattern_o), 0);
        chk("mid_rst_pending", int'(pending_o), 0);
        frame(); frame(); frame();
        chk("mid_rst_lost", int'(pattern_o), 0);

`ifdef PATTERN_SEL_AUTO_CYCLE_EN
        // Idle auto-advance after AUTOF frames, applied on the next frame
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        repeat (AUTOF - 1) begin
            tick(1'b0, 1'b0, 1'b1);
            idle(1);
        end
        chk("auto_not_yet", int'(pending_o), 0);
        tick(1'b0, 1'b0, 1'b1);
        chk("auto_target_step", int'(pending_o), 1);
        idle(1);
        tick(1'b0, 1'b0, 1'b1);
        chk("auto_applied", int'(pattern_o), 1);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
